manchester_rx_decoder: RTL and testbench



---
 rtl/manch_pkg.sv | 24 ++
 rtl/manchester_rx_decoder_if.sv | 28 ++
 rtl/sync_edge_det.sv | 34 +++
 rtl/manchester_rx_decoder.sv | 123 ++++++++++++
 tb/tb_manchester_rx_decoder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/manch_pkg.sv
// Shared types and constants for the Manchester receive path.
//   state_e               decoder FSM states
//   BIT0/1_LEVEL_AFTER_MID line level that follows the mid-bit edge of a 0 / 1
//   ERR_CNT_W             width of the saturating violation counter
package manch_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StAcq    = 2'd1,
    StLocked = 2'd2
  } state_e;

  // 0 = low-then-high, 1 = high-then-low
  localparam logic BIT0_LEVEL_AFTER_MID = 1'b1;
  localparam logic BIT1_LEVEL_AFTER_MID = 1'b0;

  localparam int unsigned ERR_CNT_W = 8;

  // Saturating increment for the violation counter.
  function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] c);
    return (c == '1) ? c : c + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/manchester_rx_decoder_if.sv
// Bundle between the line side and the Manchester decoder.
//   code        Manchester line, asynchronous to the decoder clock
//   data_out    decoded bit, held until the next data_valid
//   data_valid  one-cycle strobe qualifying data_out
//   locked      decoder has mid-bit phase
//   fail        one-cycle strobe on a coding or timing violation
//   err_cnt     saturating violation counter
// master = line source / consumer of results, slave = decoder.
interface manchester_rx_decoder_if;
  import manch_pkg::*;

  logic                 code;
  logic                 data_out;
  logic                 data_valid;
  logic                 locked;
  logic                 fail;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output code,
    input  data_out, data_valid, locked, fail, err_cnt
  );

  modport slave (
    input  code,
    output data_out, data_valid, locked, fail, err_cnt
  );
endinterface

// File: rtl/sync_edge_det.sv
// Retimes the asynchronous line into the clk domain and detects level changes.
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   code_i  raw line
//   lvl_o   synchronised (optionally inverted) line level
//   edge_o  high for one cycle after each level change of lvl_o
module sync_edge_det #(
  parameter bit INVERT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic code_i,
  output logic lvl_o,
  output logic edge_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= code_i ^ INVERT;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/manchester_rx_decoder.sv
// Oversampling Manchester decoder: acquires mid-bit phase from edge spacing and
// emits recovered NRZ bits, lock status and violation reporting.
//   clk  system sampling clock
//   rst  asynchronous active-high reset
//   rx   slave side of manchester_rx_decoder_if (code in; data_out, data_valid,
//        locked, fail, err_cnt out)
module manchester_rx_decoder
  import manch_pkg::*;
#(
  parameter int unsigned HALF_BIT = 16,
  parameter int unsigned TOL      = 4,
  parameter int unsigned INVERT   = 0
) (
  input logic                    clk,
  input logic                    rst,
  manchester_rx_decoder_if.slave rx
);

  localparam int unsigned CntW = $clog2(2 * HALF_BIT + TOL + 2);
  localparam logic [CntW-1:0] CntMax = '1;

  localparam logic [CntW:0] ShortLo = (CntW + 1)'(HALF_BIT - TOL);
  localparam logic [CntW:0] ShortHi = (CntW + 1)'(HALF_BIT + TOL);
  localparam logic [CntW:0] LongLo  = (CntW + 1)'(2 * HALF_BIT - TOL);
  localparam logic [CntW:0] LongHi  = (CntW + 1)'(2 * HALF_BIT + TOL);

  logic lvl, line_edge;

  sync_edge_det #(
    .INVERT(INVERT != 0)
  ) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .code_i(rx.code),
    .lvl_o (lvl),
    .edge_o(line_edge)
  );

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 bnd_seen_q;
  logic                 data_q;
  logic                 valid_q;
  logic                 fail_q;
  logic [ERR_CNT_W-1:0] err_q;

  // cnt restarts at 0 in the cycle after an edge, so the edge-to-edge distance
  // in cycles seen when the next edge arrives is cnt + 1.
  logic [CntW:0] ivl;
  logic          in_short, in_long, overdue;

  assign ivl      = {1'b0, cnt_q} + (CntW + 1)'(1);
  assign in_short = (ivl >= ShortLo) && (ivl <= ShortHi);
  assign in_long  = (ivl >= LongLo) && (ivl <= LongHi);
  assign overdue  = ivl > LongHi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHunt;
      cnt_q      <= '0;
      bnd_seen_q <= 1'b0;
      data_q     <= 1'b0;
      valid_q    <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
      if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      case (state_q)
        StHunt: begin
          bnd_seen_q <= 1'b0;
          if (line_edge) begin
            cnt_q   <= '0;
            state_q <= StAcq;
          end
        end
        StAcq: begin
          // Bad spacing here is acquisition noise: restart the measurement only.
          if (line_edge) begin
            cnt_q <= '0;
            if (in_long) begin
              data_q     <= (lvl == BIT1_LEVEL_AFTER_MID);
              valid_q    <= 1'b1;
              bnd_seen_q <= 1'b0;
              state_q    <= StLocked;
            end
          end else if (overdue) begin
            cnt_q <= '0;
          end
        end
        StLocked: begin
          // An edge wins over the missing-transition timeout in the same cycle.
          if (line_edge && in_long) begin
            data_q     <= (lvl == BIT1_LEVEL_AFTER_MID);
            valid_q    <= 1'b1;
            cnt_q      <= '0;
            bnd_seen_q <= 1'b0;
          end else if (line_edge && in_short && !bnd_seen_q) begin
            // Bit-boundary edge; cnt keeps measuring from the mid-bit edge.
            bnd_seen_q <= 1'b1;
          end else if (line_edge || overdue) begin
            fail_q     <= 1'b1;
            err_q      <= err_inc(err_q);
            cnt_q      <= '0;
            bnd_seen_q <= 1'b0;
            state_q    <= StHunt;
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = valid_q;
  assign rx.locked     = (state_q == StLocked);
  assign rx.fail       = fail_q;
  assign rx.err_cnt    = err_q;

endmodule

// File: tb/tb_manchester_rx_decoder.sv
// Self-checking bench for manchester_rx_decoder (HALF_BIT=16, TOL=4), with one
// plain and one inverting instance sharing the same line and reset.
module tb_manchester_rx_decoder;
  import manch_pkg::*;

  localparam int HB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b0;
  bit   sel = 1'b0;  // 0 = observe plain instance, 1 = inverting instance
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  manchester_rx_decoder_if if0 ();
  manchester_rx_decoder_if if1 ();
  assign if0.code = line;
  assign if1.code = line;

  manchester_rx_decoder #(.HALF_BIT(16), .TOL(4), .INVERT(0)) dut0 (
    .clk(clk),
    .rst(rst),
    .rx (if0)
  );
  manchester_rx_decoder #(.HALF_BIT(16), .TOL(4), .INVERT(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .rx (if1)
  );

  logic       m_dv, m_do, m_lk, m_fail;
  logic [7:0] m_err;
  assign m_dv   = sel ? if1.data_valid : if0.data_valid;
  assign m_do   = sel ? if1.data_out   : if0.data_out;
  assign m_lk   = sel ? if1.locked     : if0.locked;
  assign m_fail = sel ? if1.fail       : if0.fail;
  assign m_err  = sel ? if1.err_cnt    : if0.err_cnt;

  typedef struct {
    logic b;
    int   cyc;
  } exp_t;
  exp_t sbq[$];

  bit   sb_en = 1'b0;
  int   dv_seen = 0, fail_seen = 0, lock_drops = 0;
  int   last_dv_cyc = 0, last_fail_cyc = 0;
  logic lk_prev = 1'b0;
  int   jcur = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard / event monitor, sampling on the inactive edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_dv) begin
        dv_seen++;
        last_dv_cyc = cyc;
        if (sb_en) begin
          chk("sb_expected_pending", int'(sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("data_bit", int'(m_do), int'(e.b));
            chk("valid_latency_cyc", cyc, e.cyc);
          end
        end
      end
      if (m_fail) begin
        fail_seen++;
        last_fail_cyc = cyc;
      end
      if (lk_prev && !m_lk) lock_drops++;
    end
    lk_prev = m_lk;
  end

  function automatic int rnd(input int j);
    return (j == 0) ? 0 : int'($urandom_range(2 * j, 0)) - j;
  endfunction

  // One Manchester bit. jm / jn: timing offsets of this mid edge and of the
  // following bit boundary relative to their nominal positions.
  task automatic send_bit(input logic b, input logic eb, input bit exp, input int jm,
                          input int jn);
    line = b ^ sel;
    repeat (HB + jm - jcur) @(negedge clk);
    line = (!b) ^ sel;
    if (exp) sbq.push_back('{eb, cyc + 3});
    repeat (HB + jn - jm) @(negedge clk);
    jcur = jn;
  endtask

  // Preamble 0,1,0,1 then the first nbits of d MSB-first. The first preamble
  // bit only starts acquisition and is never decoded.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] e, input int jit,
                            input int shift_idx, input int nbits, input bit exp);
    logic [3:0] pre;
    logic       b, eb;
    int         jm, jn;
    pre = 4'b0101;
    for (int i = 0; i < 4 + nbits; i++) begin
      b  = (i < 4) ? pre[3-i] : d[11-i];
      eb = (i < 4) ? pre[3-i] : e[11-i];
      jm = (i == shift_idx) ? 6 : rnd(jit);
      jn = (i == 3 + nbits) ? 0 : rnd(jit);
      send_bit(b, eb, exp && (i > 0), jm, jn);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    line = sel;
    jcur = 0;
    sbq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    dv_seen    = 0;
    fail_seen  = 0;
    lock_drops = 0;
    lk_prev    = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;
    int         jit;
    bit         inv;
  } vec_t;
  vec_t vt[6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'hA5, 8'hA5, 0, 1'b0};
    vt[1] = '{8'hA5, 8'hA5, 2, 1'b0};
    vt[2] = '{8'h3C, 8'h3C, 2, 1'b0};
    vt[3] = '{8'h00, 8'h00, 0, 1'b0};
    vt[4] = '{8'hFF, 8'hFF, 1, 1'b0};
    vt[5] = '{8'hA5, 8'hA5, 0, 1'b1};

    // Reset held with a toggling line: everything stays at zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      line = ~line;
      chk("rst_outputs_plain", int'({if0.data_out, if0.data_valid, if0.locked, if0.fail,
                                     if0.err_cnt}), 0);
      chk("rst_outputs_inv", int'({if1.data_out, if1.data_valid, if1.locked, if1.fail,
                                   if1.err_cnt}), 0);
    end
    line = 1'b0;
    rst  = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_locked", int'(m_lk), 0);
    chk("post_rst_pulses", dv_seen + fail_seen, 0);

    // Table-driven frames: preamble + byte, exact timing or jittered within TOL.
    for (int v = 0; v < 6; v++) begin
      sel = vt[v].inv;
      do_reset();
      sb_en = 1'b1;
      send_frame(vt[v].data, vt[v].exp_bits, vt[v].jit, -1, 8, 1'b1);
      repeat (4) @(negedge clk);
      chk("vec_sb_drained", sbq.size(), 0);
      chk("vec_valid_count", dv_seen, 11);
      chk("vec_locked", int'(m_lk), 1);
      chk("vec_no_fail", fail_seen, 0);
      chk("vec_err_cnt", int'(m_err), 0);
    end
    sel = 1'b0;

    // Missing transition: line held after the last bit.
    do_reset();
    sb_en = 1'b1;
    send_frame(8'hA5, 8'hA5, 0, -1, 8, 1'b1);
    repeat (45) @(negedge clk);
    chk("miss_fail_count", fail_seen, 1);
    chk("miss_fail_delay", last_fail_cyc - last_dv_cyc, 37);
    chk("miss_no_extra_valid", dv_seen, 11);
    chk("miss_locked", int'(m_lk), 0);
    chk("miss_err_cnt", int'(m_err), 1);
    sb_en = 1'b0;

    // One mid edge late by 6: single violation, then relock.
    do_reset();
    send_frame(8'hA5, 8'hA5, 0, 9, 8, 1'b0);
    repeat (3) @(negedge clk);
    chk("late_fail_count", fail_seen, 1);
    chk("late_err_cnt", int'(m_err), 1);
    chk("late_lock_drops", lock_drops, 1);
    chk("late_relocked", int'(m_lk), 1);

    // Two SHORT edges within one bit.
    do_reset();
    send_frame(8'h00, 8'h00, 0, -1, 0, 1'b0);
    line = ~line;
    repeat (3) @(negedge clk);
    line = ~line;
    repeat (10) @(negedge clk);
    chk("dbl_fail_count", fail_seen, 1);
    chk("dbl_err_cnt", int'(m_err), 1);
    chk("dbl_locked", int'(m_lk), 0);

    // 300 more violations: lock on a LONG interval, then an edge 3 cycles later.
    for (int i = 0; i < 300; i++) begin
      line = ~line;
      repeat (32) @(negedge clk);
      line = ~line;
      repeat (3) @(negedge clk);
      line = ~line;
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("sat_fail_count", fail_seen, 301);
    chk("sat_err_cnt", int'(m_err), 255);
    chk("sat_locked", int'(m_lk), 0);

    // Inverted line, reset mid-frame, then a full restart.
    sel = 1'b1;
    do_reset();
    sb_en = 1'b1;
    send_frame(8'hA5, 8'hA5, 0, -1, 4, 1'b1);
    chk("inv_part_drained", sbq.size(), 0);
    chk("inv_part_locked", int'(m_lk), 1);
    #2 rst = 1'b1;
    #1;
    chk("inv_async_locked", int'(if1.locked), 0);
    chk("inv_async_outs", int'({if1.data_out, if1.data_valid, if1.fail, if1.err_cnt}), 0);
    do_reset();
    send_frame(8'hA5, 8'hA5, 0, -1, 8, 1'b1);
    repeat (4) @(negedge clk);
    chk("inv_restart_drained", sbq.size(), 0);
    chk("inv_restart_valids", dv_seen, 11);
    chk("inv_restart_locked", int'(m_lk), 1);
    chk("inv_restart_no_fail", fail_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
